// File: rtl/mem_arbiter.sv
// Round-robin read-port arbiter for the pixel-domain video memory.
// Priority is starved, then urgent, then normal; read data is tagged back to its requester.
module mem_arbiter #(
    parameter int NREQ         = 4,
    parameter int AW           = 16,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      urgent,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic                 mem_en,
    output logic [AW-1:0]        mem_addr,
    input  logic [DW-1:0]        mem_din,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gidx;
    logic [CW-1:0]   cnt [NREQ];
    logic [NREQ-1:0] starved;
    logic [NREQ-1:0] urg_req;

    // Closest set bit after p, wrapping: smallest circular distance wins.
    function automatic logic [NREQ-1:0] rr_pick(
        input logic [NREQ-1:0] m,
        input logic [PW-1:0]   p
    );
        logic [NREQ-1:0] g;
        int best;
        int d;
        g    = '0;
        best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + 2 * NREQ - int'(p) - 1) % NREQ;
            if (m[i] && d < best) begin
                best = d;
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [NREQ-1:0] low_pick(input logic [NREQ-1:0] m);
        logic [NREQ-1:0] g;
        g = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (m[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        starved = '0;
        for (int i = 0; i < NREQ; i++) begin
            starved[i] = req[i] && (cnt[i] == CW'(STARVE_LIMIT));
        end
    end

    assign urg_req = req & urgent;

    always_comb begin
        gnt = '0;
        if (!reset) begin
            if (|starved) begin
                gnt = low_pick(starved);
            end else if (|urg_req) begin
                gnt = rr_pick(urg_req, rr_ptr);
            end else begin
                gnt = rr_pick(req, rr_ptr);
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        gidx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_addr = req_addr[i*AW +: AW];
                gidx     = PW'(i);
            end
        end
    end

    assign mem_en = |gnt;
    assign rdata  = mem_din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= PW'(NREQ - 1);
            rvalid <= '0;
        end else begin
            rvalid <= gnt;
            if (|gnt) begin
                rr_ptr <= gidx;
            end
        end
    end

    // Counters saturate at the limit so a starved requester stays flagged until served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] || !req[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CW'(STARVE_LIMIT)) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (starve limits 15 and 3) on shared stimulus,
// checked every cycle against a queue-free behavioural model plus literal expectations.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  urgent;
    logic [15:0] a [4];
    logic [63:0] req_addr;

    logic [3:0]  gnt_w [2];
    logic        en_w  [2];
    logic [15:0] ma_w  [2];
    logic [7:0]  din_w [2];
    logic [3:0]  rv_w  [2];
    logic [7:0]  rd_w  [2];

    int n_cmp = 0;
    int n_bad = 0;

    assign req_addr = {a[3], a[2], a[1], a[0]};

    mem_arbiter #(.NREQ(4), .AW(16), .DW(8), .STARVE_LIMIT(15)) dut0 (
        .clk(clk), .reset(reset), .req(req), .urgent(urgent),
        .req_addr(req_addr), .gnt(gnt_w[0]), .mem_en(en_w[0]),
        .mem_addr(ma_w[0]), .mem_din(din_w[0]), .rvalid(rv_w[0]),
        .rdata(rd_w[0])
    );

    mem_arbiter #(.NREQ(4), .AW(16), .DW(8), .STARVE_LIMIT(3)) dut1 (
        .clk(clk), .reset(reset), .req(req), .urgent(urgent),
        .req_addr(req_addr), .gnt(gnt_w[1]), .mem_en(en_w[1]),
        .mem_addr(ma_w[1]), .mem_din(din_w[1]), .rvalid(rv_w[1]),
        .rdata(rd_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [15:0] ad);
        return ad[7:0] ^ ad[15:8] ^ 8'h5A;
    endfunction

    // Synchronous-read memory, one per instance
    always @(posedge clk) begin
        din_w[0] <= memf(ma_w[0]);
        din_w[1] <= memf(ma_w[1]);
    end

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model state
    int          lim [2] = '{15, 3};
    int          m_ptr [2];
    int          m_cnt [2][4];
    logic [3:0]  m_rv [2];
    logic [15:0] m_ra [2];
    int          eg [2];

    function automatic int pick(input int d);
        int j;
        for (int i = 0; i < 4; i++)
            if (req[i] && m_cnt[d][i] == lim[d]) return i;
        for (int k = 1; k <= 4; k++) begin
            j = (m_ptr[d] + k) % 4;
            if (req[j] && urgent[j]) return j;
        end
        for (int k = 1; k <= 4; k++) begin
            j = (m_ptr[d] + k) % 4;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] oh(input int g);
        logic [3:0] v;
        v = 4'b0000;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    always begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_ptr[d] = 3;
                m_rv[d]  = 4'b0000;
                for (int i = 0; i < 4; i++) m_cnt[d][i] = 0;
            end
            eg[d] = reset ? -1 : pick(d);
            chk($sformatf("gnt%0d", d), 16'(gnt_w[d]), 16'(oh(eg[d])));
            chk($sformatf("en%0d", d), 16'(en_w[d]), 16'(eg[d] >= 0));
            chk($sformatf("addr%0d", d), ma_w[d],
                (eg[d] >= 0) ? a[eg[d]] : 16'h0000);
            chk($sformatf("rvalid%0d", d), 16'(rv_w[d]), 16'(m_rv[d]));
            if (m_rv[d] != 4'b0000)
                chk($sformatf("rdata%0d", d), 16'(rd_w[d]),
                    16'(memf(m_ra[d])));
        end
        @(posedge clk);
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) begin
                    if (i == eg[d] || !req[i]) m_cnt[d][i] = 0;
                    else if (m_cnt[d][i] < lim[d]) m_cnt[d][i]++;
                end
                if (eg[d] >= 0) begin
                    m_ptr[d] = eg[d];
                    m_ra[d]  = a[eg[d]];
                end
                m_rv[d] = oh(eg[d]);
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic [3:0] u,
                        input logic [15:0] a3);
        @(posedge clk);
        #1;
        req    = r;
        urgent = u;
        a[3]   = a3;
        @(negedge clk);
    endtask

    logic [3:0] seq4 [6] = '{4'b0001, 4'b0001, 4'b0001,
                             4'b0010, 4'b1000, 4'b0001};

    initial begin
        reset  = 1'b1;
        req    = 4'b0000;
        urgent = 4'b0000;
        for (int i = 0; i < 4; i++) a[i] = 16'h2000 + 16'(i);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset
        step(4'b0000, 4'b0000, 16'h2003);
        chk("idle_gnt", 16'(gnt_w[0]), 16'h0000);
        chk("idle_en", 16'(en_w[0]), 16'h0000);
        chk("idle_rv", 16'(rv_w[0]), 16'h0000);

        // Plain round robin
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 4'b0000, 16'h2003);
            chk("rr_gnt", 16'(gnt_w[0]), 16'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk("rr_rv", 16'(rv_w[0]), 16'(4'b0001 << ((k - 1) % 4)));
                chk("rr_rdata", 16'(rd_w[0]),
                    16'(memf(16'h2000 + 16'((k - 1) % 4))));
            end
        end
        step(4'b0000, 4'b0000, 16'h2003);
        chk("rr_rv_last", 16'(rv_w[0]), 16'h0008);

        // Urgent hogging until requester 0 starves out at 15
        for (int k = 1; k <= 17; k++) begin
            step(4'b0101, 4'b0100, 16'h2003);
            chk("starve15", 16'(gnt_w[0]), (k == 16) ? 16'h0001 : 16'h0004);
        end
        step(4'b0000, 4'b0000, 16'h2003);

        // Two starved at limit 3 beat an urgent requester, lowest first
        for (int k = 0; k < 6; k++) begin
            step(4'b1011, 4'b0001, 16'h2003);
            chk("starve3", 16'(gnt_w[1]), 16'(seq4[k]));
        end
        step(4'b0000, 4'b0000, 16'h2003);

        // Single requester, back-to-back, changing address
        for (int k = 0; k < 4; k++) begin
            step(4'b1000, 4'b0000, 16'h1000 + 16'(k));
            chk("single_gnt", 16'(gnt_w[0]), 16'h0008);
            chk("single_addr", ma_w[0], 16'h1000 + 16'(k));
            if (k > 0) begin
                chk("single_rv", 16'(rv_w[0]), 16'h0008);
                chk("single_rdata", 16'(rd_w[0]),
                    16'(memf(16'h1000 + 16'(k - 1))));
            end
        end
        step(4'b0000, 4'b0000, 16'h1003);
        chk("single_rv_tail", 16'(rv_w[0]), 16'h0008);
        chk("single_rdata_tail", 16'(rd_w[0]), 16'(memf(16'h1003)));
        step(4'b0000, 4'b0000, 16'h2003);
        chk("single_rv_done", 16'(rv_w[0]), 16'h0000);

        // Dropped request clears its counter: limit-3 instance never starves it
        step(4'b0011, 4'b0001, 16'h2003);
        chk("drop_a", 16'(gnt_w[1]), 16'h0001);
        step(4'b0011, 4'b0001, 16'h2003);
        chk("drop_b", 16'(gnt_w[1]), 16'h0001);
        step(4'b0001, 4'b0001, 16'h2003);
        chk("drop_c", 16'(gnt_w[1]), 16'h0001);
        chk("drop_rv1", 16'(rv_w[0][1]), 16'h0000);
        step(4'b0011, 4'b0001, 16'h2003);
        chk("drop_d", 16'(gnt_w[1]), 16'h0001);
        step(4'b0011, 4'b0001, 16'h2003);
        chk("drop_e", 16'(gnt_w[1]), 16'h0001);
        chk("drop_rv1b", 16'(rv_w[1][1]), 16'h0000);
        step(4'b0000, 4'b0000, 16'h2003);

        // Reset mid-stream drops the in-flight return
        step(4'b0100, 4'b0000, 16'h2003);
        chk("mid_gnt", 16'(gnt_w[0]), 16'h0004);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rv", 16'(rv_w[0]), 16'h0000);
        chk("mid_gnt_rst", 16'(gnt_w[0]), 16'h0000);
        chk("mid_en_rst", 16'(en_w[0]), 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        chk("post_rst_rv", 16'(rv_w[0]), 16'h0000);
        step(4'b0000, 4'b0000, 16'h2003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
